// File: rtl/autosym_eval_pipe.sv
// autosym_eval_pipe: two-stage evaluator of f(x) = g(A*x ^ c) over GF(2),
// with rows of A, constant c and truth table g loaded through a serial config port.
module autosym_eval_pipe #(
   parameter int N_IN    = 6,
   parameter int K       = 4,
   parameter int INV_OUT = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic [N_IN:0]   cfg_data,
   output logic            cfg_done,
   output logic            cfg_loaded,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N_IN-1:0] in_x,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_y
);
   localparam int TS = 1 << K;
   localparam int NB = K + TS;
   localparam int CW = $clog2(NB);
   typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_t;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [K-1:0][N_IN-1:0] mask_q, mask_d;
   logic [K-1:0]           c_q, c_d;
   logic [TS-1:0]          tbl_q, tbl_d;
   logic                   s1_v_q, s2_v_q, s2_y_q;
   logic [K-1:0]           s1_y_q, y;
   logic                   beat, s1_adv, s2_adv;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      c_d      = c_q;
      tbl_d    = tbl_q;
      beat     = (state_q == LOAD) && cfg_valid && !cfg_start;
      cfg_done = beat && (cnt_q == CW'(NB - 1));
      if (cfg_start) begin
         state_d = LOAD;
         cnt_d   = '0;
      end else if (beat) begin
         cnt_d = cfg_done ? cnt_q : cnt_q + CW'(1);
         for (int i = 0; i < K; i++)
            if (cnt_q == CW'(i)) begin
               mask_d[i] = cfg_data[N_IN-1:0];
               c_d[i]    = cfg_data[N_IN];
            end
         for (int j = 0; j < TS; j++)
            if (cnt_q == CW'(K + j)) tbl_d[j] = cfg_data[0];
         if (cfg_done) state_d = RUN;
      end
   end
   always_comb begin
      y = '0;
      for (int i = 0; i < K; i++) y[i] = ^(in_x & mask_q[i]) ^ c_q[i];
   end
   assign cfg_loaded = state_q == RUN;
   assign s2_adv     = !s2_v_q || out_ready;
   assign s1_adv     = !s1_v_q || s2_adv;
   assign in_ready   = cfg_loaded && !cfg_start && s1_adv;
   assign out_valid  = s2_v_q;
   assign out_y      = s2_y_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= UNCFG;
         cnt_q   <= '0;
         mask_q  <= '0;
         c_q     <= '0;
         tbl_q   <= '0;
         s1_v_q  <= 1'b0;
         s1_y_q  <= '0;
         s2_v_q  <= 1'b0;
         s2_y_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         c_q     <= c_d;
         tbl_q   <= tbl_d;
         // a restart discards everything in flight, including a stalled result
         if (cfg_start) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
         end else begin
            if (s2_adv) begin
               s2_v_q <= s1_v_q;
               s2_y_q <= tbl_q[s1_y_q] ^ 1'(INV_OUT);
            end
            if (s1_adv) begin
               s1_v_q <= in_valid && in_ready;
               s1_y_q <= y;
            end
         end
      end
   end
endmodule

// File: tb/tb_autosym_eval_pipe.sv
// tb_autosym_eval_pipe: scoreboard bench driving a plain and an inverted-output
// autosym_eval_pipe with identical stimulus, checked against a parity/lookup model.
module tb_autosym_eval_pipe;
   localparam int N  = 6;
   localparam int K  = 4;
   localparam int TS = 1 << K;
   localparam int NB = K + TS;
   localparam int DW = N + 1;
   localparam int RW = K * DW;
   logic          clk = 1'b0, rst_n = 1'b1;
   logic          cfg_start = 1'b0, cfg_valid = 1'b0;
   logic [DW-1:0] cfg_data = '0;
   logic          in_valid = 1'b0, out_ready = 1'b1;
   logic [N-1:0]  in_x = '0;
   logic          cfg_done, cfg_loaded, in_ready, out_valid, out_y;
   logic          cfg_done_n, cfg_loaded_n, in_ready_n, out_valid_n, out_y_n;
   int            n_chk = 0, n_fail = 0;
   logic          q[$];
   logic [RW-1:0] m_rows = '0;
   logic [TS-1:0] m_tbl = '0;
   logic          m_loaded = 1'b0, acc = 1'b0;
   int            mode = 0, cyc = 0;
   logic          pv = 1'b0, pr = 1'b0, py = 1'b0, ps = 1'b0;

   always #5 clk = ~clk;

   autosym_eval_pipe #(.N_IN(N), .K(K), .INV_OUT(0)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_done(cfg_done), .cfg_loaded(cfg_loaded), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y));

   autosym_eval_pipe #(.N_IN(N), .K(K), .INV_OUT(1)) dut_inv (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_done(cfg_done_n), .cfg_loaded(cfg_loaded_n), .in_valid(in_valid), .in_ready(in_ready_n),
      .in_x(in_x), .out_valid(out_valid_n), .out_ready(out_ready), .out_y(out_y_n));

   task automatic check(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // f(x): y_i is the parity of the masked inputs flipped by c_i; the table is indexed by y
   function automatic logic model(input logic [N-1:0] x);
      int            idx = 0;
      logic [DW-1:0] row;
      logic [TS-1:0] t;
      for (int i = 0; i < K; i++) begin
         row = DW'(m_rows >> (i * DW));
         if (($countones(x & row[N-1:0]) + int'(row[N])) % 2 == 1) idx += 1 << i;
      end
      t = m_tbl >> idx;
      return t[0];
   endfunction

   initial forever begin
      @(posedge clk); #1;
      cyc++;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ((cyc % 4 == 0) || (cyc % 4 == 3)) :
                  mode == 2 ? 1'($urandom_range(1)) : 1'b0;
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (ps) check("flush out_valid", out_valid, 1'b0);
         else if (pv && !pr) begin
            check("stall hold valid", out_valid, 1'b1);
            check("stall hold y", out_y, py);
         end
         if (out_valid) begin
            if (q.size() == 0) check("unexpected output", out_valid, 1'b0);
            else begin
               check("out_y", out_y, q[0]);
               check("out_valid inv", out_valid_n, 1'b1);
               check("out_y inv", out_y_n, ~q[0]);
               if (out_ready) void'(q.pop_front());
            end
         end
         pv = out_valid; pr = out_ready; py = out_y; ps = cfg_start;
      end
   end

   task automatic sample();
      @(negedge clk); #1;
      acc = 1'b0;
      if (rst_n) begin
         check("in_ready", in_ready, m_loaded && !cfg_start && (out_ready || q.size() < 2));
         check("cfg_loaded", cfg_loaded, m_loaded);
         acc = in_valid && in_ready;
         if (acc) q.push_back(model(in_x));
         if (cfg_start) q.delete();
      end
   endtask

   task automatic step();
      sample();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [N-1:0] x);
      int n = 0;
      in_valid = 1'b1;
      in_x = x;
      do begin
         step();
         n++;
      end while (!acc && n < 50);
      in_valid = 1'b0;
      check("send accepted", acc, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      mode = 0;
      while (q.size() > 0 && n < 20) begin
         step();
         n++;
      end
      check("drain", q.size() == 0, 1'b1);
   endtask

   task automatic load_cfg(input logic [RW-1:0] rows, input logic [TS-1:0] tbl, input logic restart);
      logic [TS-1:0] sh;
      cfg_start = 1'b1;
      cfg_valid = restart;
      cfg_data = DW'($urandom());
      step();
      cfg_start = 1'b0;
      m_loaded = 1'b0;
      if (restart) begin
         repeat (3) begin
            cfg_valid = 1'b1;
            cfg_data = DW'($urandom());
            step();
         end
         cfg_start = 1'b1;
         cfg_data = DW'($urandom());
         step();
         cfg_start = 1'b0;
      end
      for (int b = 0; b < NB; b++) begin
         while ($urandom_range(3) == 0) begin
            cfg_valid = 1'b0;
            cfg_data = DW'($urandom());
            sample();
            check("cfg_done idle", cfg_done, 1'b0);
            @(posedge clk); #1;
         end
         cfg_valid = 1'b1;
         if (b < K) cfg_data = DW'(rows >> (b * DW));
         else begin
            sh = tbl >> (b - K);
            cfg_data = DW'($urandom());
            cfg_data[0] = sh[0];
         end
         sample();
         check("cfg_done", cfg_done, b == NB - 1);
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      m_rows = rows;
      m_tbl = tbl;
      m_loaded = 1'b1;
   endtask

   task automatic check_reset_outputs();
      check("rst cfg_done", cfg_done, 1'b0);
      check("rst cfg_loaded", cfg_loaded, 1'b0);
      check("rst in_ready", in_ready, 1'b0);
      check("rst out_valid", out_valid, 1'b0);
      check("rst out_y", out_y, 1'b0);
      check("rst out_valid inv", out_valid_n, 1'b0);
      check("rst out_y inv", out_y_n, 1'b0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) step();
      // identity rows, table selects y == 4'b1111 only
      load_cfg({7'h08, 7'h04, 7'h02, 7'h01}, 16'h8000, 1'b0);
      send(6'b001111);
      sample();
      check("latency 1 cycle", out_valid, 1'b0);
      @(posedge clk); #1;
      sample();
      check("latency 2 cycles", out_valid, 1'b1);
      @(posedge clk); #1;
      send(6'b110111);
      drain();
      // affine constant on row 0
      load_cfg({7'h00, 7'h00, 7'h00, 7'h43}, 16'h0002, 1'b0);
      send(6'b000000);
      send(6'b000001);
      send(6'b000011);
      drain();
      // back-to-back under 1,0,0,1 backpressure with a restarted load
      mode = 1;
      load_cfg(RW'({$urandom(), $urandom()}), TS'($urandom()), 1'b1);
      for (int i = 0; i < 8; i++) send(N'($urandom()));
      drain();
      // random gaps and random backpressure
      load_cfg(RW'({$urandom(), $urandom()}), TS'($urandom()), 1'b0);
      mode = 2;
      repeat (40) begin
         if ($urandom_range(3) == 0) step();
         send(N'($urandom()));
      end
      drain();
      // reconfigure with two results in flight
      mode = 3;
      step();
      send(N'($urandom()));
      send(N'($urandom()));
      load_cfg(RW'({$urandom(), $urandom()}), TS'($urandom()), 1'b0);
      mode = 0;
      repeat (6) send(N'($urandom()));
      drain();
      // asynchronous reset with a full, stalled pipeline
      load_cfg(RW'({$urandom(), $urandom()}), '1, 1'b0);
      mode = 3;
      step();
      in_valid = 1'b1;
      repeat (4) begin
         in_x = N'($urandom());
         step();
      end
      in_valid = 1'b0;
      check("pre-reset out_valid", out_valid, 1'b1);
      check("pre-reset out_y", out_y, 1'b1);
      @(negedge clk); #3 rst_n = 1'b0;
      #1 check_reset_outputs();
      q.delete();
      m_loaded = 1'b0;
      pv = 1'b0;
      ps = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      mode = 0;
      repeat (3) step();
      load_cfg({7'h08, 7'h04, 7'h02, 7'h01}, 16'h8000, 1'b0);
      send(6'b001111);
      send(6'b110111);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "timeout");
   end
endmodule
